// File: rtl/diff_freq_serial_in_if.sv
// Host-side handshake and capture-line bundle for diff_freq_serial_in.
// The master modport is the host/UART side; the slave modport is the capture block.
interface diff_freq_serial_in_if;
  logic [7:0] i_data;
  logic       i_rx_done_tick;
  logic       i_serial_in;
  logic       i_tx_done_tick;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       o_bit_tick;
  logic       o_busy;
  logic       o_done_tick;

  modport master (
    output i_data, i_rx_done_tick, i_serial_in, i_tx_done_tick,
    input  o_tx_start, o_tx_data, o_bit_tick, o_busy, o_done_tick
  );

  modport slave (
    input  i_data, i_rx_done_tick, i_serial_in, i_tx_done_tick,
    output o_tx_start, o_tx_data, o_bit_tick, o_busy, o_done_tick
  );
endinterface

// File: rtl/diff_freq_serial_in.sv
// Captures DATA_BIT serial bits with a per-bit low/high-speed period chosen by a UART-loaded
// pattern, then returns the word over UART. Optional macro SERIAL_IN_SYNC_EN adds a 2-flop sync.
module diff_freq_serial_in #(
  parameter int unsigned DATA_BIT = 32,
  parameter int unsigned PACK_NUM = 5,
  parameter int unsigned LOW_DIV  = 40,
  parameter int unsigned HIGH_DIV = 10,
  parameter int unsigned DIV_BIT  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  diff_freq_serial_in_if.slave bus
);
  localparam int unsigned NBYTES = DATA_BIT / 8;
  localparam int unsigned BW     = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
  localparam int unsigned KW     = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
  localparam int unsigned JW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {StIdle, StCapture, StSend, StWaitTx, StDone} state_e;

  state_e                state_q, state_d;
  logic [BW-1:0]         byte_cnt_q, byte_cnt_d;
  logic [KW-1:0]         bit_idx_q, bit_idx_d;
  logic [DIV_BIT-1:0]    div_cnt_q, div_cnt_d;
  logic [JW-1:0]         byte_sel_q, byte_sel_d;
  logic [DATA_BIT-1:0]   freq_q, freq_d;
  logic [DATA_BIT-1:0]   shift_q, shift_d;
  logic [DIV_BIT-1:0]    period;
  logic [DIV_BIT-1:0]    half;
  logic                  sample;

`ifdef SERIAL_IN_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], bus.i_serial_in};
    end
  end

  assign sample = sync_q[1];
`else
  assign sample = bus.i_serial_in;
`endif

  // Period of the bit currently being captured; freq_q is frozen outside IDLE.
  assign period = freq_q[bit_idx_q] ? DIV_BIT'(HIGH_DIV) : DIV_BIT'(LOW_DIV);
  assign half   = period >> 1;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      bit_idx_q  <= '0;
      div_cnt_q  <= '0;
      byte_sel_q <= '0;
      freq_q     <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_idx_q  <= bit_idx_d;
      div_cnt_q  <= div_cnt_d;
      byte_sel_q <= byte_sel_d;
      freq_q     <= freq_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bit_idx_d  = bit_idx_q;
    div_cnt_d  = div_cnt_q;
    byte_sel_d = byte_sel_q;
    freq_d     = freq_q;
    shift_d    = shift_q;

    unique case (state_q)
      StIdle: begin
        if (bus.i_rx_done_tick) begin
          if (byte_cnt_q == BW'(PACK_NUM - 1)) begin
            byte_cnt_d = '0;
            if (bus.i_data[0]) begin
              state_d   = StCapture;
              bit_idx_d = '0;
              div_cnt_d = '0;
            end
          end else begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
              if (byte_cnt_q == BW'(b)) freq_d[b*8 +: 8] = bus.i_data;
            end
            byte_cnt_d = byte_cnt_q + BW'(1);
          end
        end
      end
      StCapture: begin
        if (div_cnt_q == half) shift_d[bit_idx_q] = sample;
        if (div_cnt_q == period - DIV_BIT'(1)) begin
          div_cnt_d = '0;
          if (bit_idx_q == KW'(DATA_BIT - 1)) begin
            state_d    = StSend;
            byte_sel_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + KW'(1);
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_BIT'(1);
        end
      end
      StSend: begin
        state_d = StWaitTx;
      end
      StWaitTx: begin
        if (bus.i_tx_done_tick) begin
          if (byte_sel_q == JW'(NBYTES - 1)) begin
            state_d = StDone;
          end else begin
            byte_sel_d = byte_sel_q + JW'(1);
            state_d    = StSend;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode straight from state, so an asynchronous reset clears them at once.
  always_comb begin
    bus.o_tx_start  = (state_q == StSend);
    bus.o_bit_tick  = (state_q == StCapture) && (div_cnt_q == half);
    bus.o_busy      = (state_q != StIdle);
    bus.o_done_tick = (state_q == StDone);
    bus.o_tx_data   = '0;
    for (int unsigned b = 0; b < NBYTES; b++) begin
      if (byte_sel_q == JW'(b)) bus.o_tx_data = shift_q[b*8 +: 8];
    end
  end

endmodule

// File: doc/diff_freq_serial_in.md
Name: diff_freq_serial_in

Overview:
Capture-side counterpart of diff_freq_serial_out.
- Host sends a configuration packet over UART: a 32-bit frequency pattern plus a control byte.
- On start, the block samples DATA_BIT bits from one serial input. Each bit uses a low- or high-speed bit period selected per bit by the frequency pattern.
- The captured word is returned to the host as bytes through the UART TX handshake.
- Sits between the UART rx/tx ports and the external serial line under test.

Parameters:
- DATA_BIT, 32: captured bits per frame; multiple of 8.
- PACK_NUM, 5: config bytes per packet, (DATA_BIT+8)/8.
- LOW_DIV, 40: clocks per low-speed bit; must be ≥2.
- HIGH_DIV, 10: clocks per high-speed bit; must be ≥2.
- DIV_BIT, 8: counter width; must satisfy 2^DIV_BIT > max(LOW_DIV, HIGH_DIV).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-high.
- i_data, input, 8: UART rx byte.
- i_rx_done_tick, input, 1: one-cycle strobe, i_data valid.
- i_serial_in, input, 1: serial line under capture.
- i_tx_done_tick, input, 1: UART tx finished the current byte.
- o_tx_start, output, 1: one-cycle request to send o_tx_data.
- o_tx_data, output, 8: byte to transmit.
- o_bit_tick, output, 1: one-cycle pulse at each sample instant.
- o_busy, output, 1: high while not in IDLE.
- o_done_tick, output, 1: one-cycle pulse after the last byte is acknowledged.

Behaviour:
Reset (rst_n high, asynchronous):
- All outputs 0.
- State IDLE; byte counter, bit index and divide counter cleared.
- freq_reg and shift_reg = 0.

Config packet (accepted in IDLE only):
- Bytes arrive LSB first: bytes 0..3 fill freq_reg[7:0]..[31:24]; byte 4 is the control byte.
- Byte counter wraps to 0 after byte PACK_NUM-1.
- Control bit0 = start; bits[7:1] are ignored.
- Control byte with start=1: enter CAPTURE on the next clock.
- Control byte with start=0: store freq_reg only and stay in IDLE.
- i_rx_done_tick outside IDLE is ignored; the byte counter is frozen.

CAPTURE:
- Bit index k runs 0..DATA_BIT-1.
- Period P = HIGH_DIV if freq_reg[k]=1, else LOW_DIV.
- Divide counter counts 0..P-1.
- At count == P/2 (integer division):
  - sample the line into shift_reg[k], so the first bit received is the LSB;
  - pulse o_bit_tick.
- At count == P-1: reset count and increment k.
- After bit DATA_BIT-1 completes its full period, go to SEND.
- Total CAPTURE length = sum of the per-bit periods. With all bits low speed at defaults: 1280 cycles.

SEND:
- Drive o_tx_data = shift_reg byte j (j=0 first, bits[7:0]).
- Pulse o_tx_start for one cycle, then go to WAIT_TX.

WAIT_TX:
- On i_tx_done_tick: if j < DATA_BIT/8-1, increment j and return to SEND. Otherwise go to DONE.
- o_tx_data holds stable from SEND until i_tx_done_tick.

DONE:
- Pulse o_done_tick for one cycle, then return to IDLE.
- freq_reg is kept; shift_reg is kept until the next capture overwrites it.

o_busy is 1 in CAPTURE, SEND, WAIT_TX and DONE.

Boundary conditions:
- i_tx_done_tick in any state other than WAIT_TX is ignored.
- Reset asserted mid-capture or mid-send aborts immediately; no further o_tx_start is issued.
- Simultaneous i_rx_done_tick and i_tx_done_tick in WAIT_TX: rx is ignored, tx is handled.
- freq_reg is not modified during CAPTURE.

Optional Feature:
SERIAL_IN_SYNC_EN:
- Defined: i_serial_in passes through a 2-flop synchronizer before sampling. The sampled value reflects the line 2 clocks earlier; bit timing is otherwise unchanged. Both flops reset to 0.
- Undefined: i_serial_in is sampled directly, no added latency.

Test Plan:
1. Config bytes 00 00 00 00 01, bench drives pattern 0xAA55FF00 LSB first with 40-clock bits aligned to the start -> 32 o_bit_tick pulses spaced 40 cycles apart, first at cycle 20 after CAPTURE entry; tx bytes 00, FF, 55, AA in order; one o_done_tick.
2. Config FF FF 00 00 01: low 16 bits at HIGH_DIV, upper 16 bits at LOW_DIV, input 0x12345678 -> o_bit_tick spacing 10 then 40 cycles; CAPTURE length 800 cycles; tx 78 56 34 12.
3. Config with control 00, then a later packet with control 01 -> no capture after the first packet; the second packet's freq_reg is used.
4. Extra i_rx_done_tick bytes during CAPTURE -> ignored; after DONE, a fresh 5-byte packet is accepted from byte 0.
5. Bench delays i_tx_done_tick by 500 cycles per byte -> o_tx_data stable throughout each wait; exactly 4 o_tx_start pulses.
6. rst_n asserted at bit 17 of a capture -> all outputs 0 immediately, state IDLE; the next full packet captures normally.
